// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin scheduler that shares one 32-bit LFSR engine among
// NREQ burst requesters and streams its words through a valid/ready port.
// Optional build macro LFSR_SCHED_STATS_EN adds the words_total handshake counter.
module lfsr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LENW = 4,
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] req_len,
  output logic [NREQ-1:0]      gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_last,
  input  logic                 reseed_valid,
  input  logic [31:0]          reseed_seed,
  output logic                 reseed_ready,
  output logic                 busy,
  output logic                 lfsr_en,
  output logic                 lfsr_load,
  output logic [31:0]          lfsr_seed,
`ifdef LFSR_SCHED_STATS_EN
  output logic [31:0]          words_total,
`endif
  input  logic [31:0]          lfsr_q
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_STREAM,
    S_RESEED
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            out_valid_q, out_valid_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [31:0]     seed_q, seed_d;
  logic [IDXW-1:0] pick;
  logic [LENW-1:0] pick_len;
  logic [LENW-1:0] eff_len;
  logic            hs;

  assign hs = out_valid_q & out_ready;

  // Round-robin pick: first requester above the pointer, wrapping; the
  // descending scan leaves the nearest hit as the final assignment.
  always_comb begin
    pick     = ptr_q;
    pick_len = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      if (req[IDXW'((32'(ptr_q) + k) % NREQ)]) begin
        pick = IDXW'((32'(ptr_q) + k) % NREQ);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDXW'(i) == pick) begin
        pick_len = req_len[i*LENW +: LENW];
      end
    end
    eff_len = (pick_len == '0) ? LENW'(1) : pick_len;
  end

  // Next-state and datapath-register update logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    case (state_q)
      S_INIT: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (reseed_valid) begin
          seed_d  = (reseed_seed == 32'd0) ? SEED : reseed_seed;
          state_d = S_RESEED;
        end else if (|req) begin
          gnt_d       = NREQ'(1) << pick;
          gidx_d      = pick;
          cnt_d       = eff_len;
          out_valid_d = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs) begin
          cnt_d = cnt_q - LENW'(1);
          if (cnt_q == LENW'(1)) begin
            ptr_d       = gidx_q;
            gnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      S_RESEED: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_INIT;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= IDXW'(NREQ - 1);
      gidx_q      <= '0;
      cnt_q       <= '0;
      seed_q      <= SEED;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
    end
  end

  // LFSR control decodes from state; stepping follows the handshake directly.
  always_comb begin
    lfsr_en      = hs;
    lfsr_load    = (state_q == S_INIT) || (state_q == S_RESEED);
    lfsr_seed    = (state_q == S_RESEED) ? seed_q : SEED;
    busy         = (state_q != S_IDLE);
    reseed_ready = (state_q == S_IDLE);
    gnt          = gnt_q;
    out_valid    = out_valid_q;
    out_data     = lfsr_q;
    out_last     = out_valid_q && (cnt_q == LENW'(1));
  end

`ifdef LFSR_SCHED_STATS_EN
  logic [31:0] words_q;

  // Free-running handshake counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      words_q <= '0;
    end else if (hs) begin
      words_q <= words_q + 32'd1;
    end
  end

  assign words_total = words_q;
`else
  // Statistics counter not present in this build.
`endif

endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: randomized and directed bench for lfsr_sched with an
// in-bench LFSR engine and a transaction-level expectation model.
module tb_lfsr_sched;

  localparam int NREQ = 4;
  localparam int LENW = 4;
  localparam int IW   = $clog2(NREQ);
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      gnt;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic                 out_last;
  logic                 reseed_valid;
  logic [31:0]          reseed_seed;
  logic                 reseed_ready;
  logic                 busy;
  logic                 lfsr_en;
  logic                 lfsr_load;
  logic [31:0]          lfsr_seed;
  logic [31:0]          lfsr_q = 32'd0;
`ifdef LFSR_SCHED_STATS_EN
  logic [31:0]          words_total;
`endif

  always #5 clk = ~clk;

  lfsr_sched #(.NREQ(NREQ), .LENW(LENW), .SEED(SEED)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_len(req_len),
    .gnt(gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .reseed_valid(reseed_valid),
    .reseed_seed(reseed_seed),
    .reseed_ready(reseed_ready),
    .busy(busy),
    .lfsr_en(lfsr_en),
    .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed),
`ifdef LFSR_SCHED_STATS_EN
    .words_total(words_total),
`endif
    .lfsr_q(lfsr_q)
  );

  // 32-bit Fibonacci LFSR, taps 32,22,2,1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  // The shared LFSR engine the scheduler controls.
  always @(posedge clk) begin
    if (lfsr_load)    lfsr_q <= lfsr_seed;
    else if (lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next owner: first set request above the last owner, wrapping.
  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    int i;
    for (int k = 1; k <= NREQ; k++) begin
      i = (last + k) % NREQ;
      if (r[IW'(i)]) return i;
    end
    return last;
  endfunction

  // Model: a pending seed load, or a burst with words left, or idle.
  bit              known = 1'b0;
  bit              m_load = 1'b0;
  logic [31:0]     m_load_val = 32'd0;
  int              m_left = 0;
  int              m_owner = 0;
  int              m_last = NREQ - 1;
  logic [31:0]     m_lfsr = 32'd0;
  logic [31:0]     m_words = 32'd0;
  logic [NREQ-1:0] exp_gnt;
  logic [LENW-1:0] fld;
  bit              m_idle;

  // Observation logs for directed checks.
  int              en_count = 0;
  int              last_count = 0;
  logic [31:0]     hs_words[$];
  logic [31:0]     loads[$];
  logic [NREQ-1:0] grants[$];
  logic [NREQ-1:0] prev_gnt = '0;

  // Compare DUT against the model each cycle, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (known) begin
        m_idle  = !m_load && (m_left == 0);
        exp_gnt = (m_left > 0) ? (NREQ'(1) << m_owner) : '0;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("out_valid", 32'(out_valid), 32'(m_left > 0));
        chk("out_last", 32'(out_last), 32'(m_left == 1));
        chk("lfsr_en", 32'(lfsr_en), 32'((m_left > 0) && out_ready));
        chk("lfsr_load", 32'(lfsr_load), 32'(m_load));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("reseed_ready", 32'(reseed_ready), 32'(m_idle));
        chk("en_load_excl", 32'(lfsr_en & lfsr_load), 32'd0);
        if (m_left > 0) chk("out_data", out_data, m_lfsr);
        if (m_load) chk("lfsr_seed", lfsr_seed, m_load_val);
`ifdef LFSR_SCHED_STATS_EN
        chk("words_total", words_total, m_words);
`endif
      end
      if (lfsr_en) en_count++;
      if (out_valid && out_ready) begin
        hs_words.push_back(out_data);
        if (out_last) last_count++;
      end
      if (lfsr_load) loads.push_back(lfsr_seed);
      if (gnt != '0 && prev_gnt == '0) grants.push_back(gnt);
      prev_gnt = gnt;

      if (!rst) begin
        known      = 1'b1;
        m_load     = 1'b1;
        m_load_val = SEED;
        m_left     = 0;
        m_last     = NREQ - 1;
        m_words    = 32'd0;
      end else if (known) begin
        if (m_load) begin
          m_lfsr = m_load_val;
          m_load = 1'b0;
        end else if (m_left > 0) begin
          if (out_ready) begin
            m_lfsr  = lfsr_next(m_lfsr);
            m_words = m_words + 32'd1;
            m_left--;
            if (m_left == 0) m_last = m_owner;
          end
        end else if (reseed_valid) begin
          m_load     = 1'b1;
          m_load_val = (reseed_seed == 32'd0) ? SEED : reseed_seed;
        end else if (req != '0) begin
          m_owner = rr_next(req, m_last);
          fld     = LENW'(req_len >> (m_owner * LENW));
          m_left  = (fld == '0) ? 1 : int'(fld);
        end
      end
    end
  end

  task automatic wait_idle(input int maxc);
    int n = 0;
    @(negedge clk);
    #1;
    while (busy && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic burst(input logic [NREQ-1:0] r);
    req = r;
    @(negedge clk);
    req = '0;
  endtask

  logic [5:0] patv;

  initial begin
    rst = 1'b0; req = '0; req_len = '0; out_ready = 1'b1;
    reseed_valid = 1'b0; reseed_seed = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("init_load", 32'(lfsr_load), 32'd1);
    chk("init_seed", lfsr_seed, 32'h1);
    @(negedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_reseed_ready", 32'(reseed_ready), 32'd1);

    // Single burst of 3 from requester 0.
    hs_words.delete(); en_count = 0; last_count = 0;
    req_len = 16'h0003;
    burst(4'b0001);
    wait_idle(40);
    chk("single_hs", 32'(hs_words.size()), 32'd3);
    chk("single_w0", hs_words[0], 32'h1);
    chk("single_w1", hs_words[1], 32'h3);
    chk("single_w2", hs_words[2], 32'h6);
    chk("single_en", 32'(en_count), 32'd3);
    chk("single_last", 32'(last_count), 32'd1);

    // Round-robin: park pointer at 3, then hold 1011 with all lengths 1.
    req_len = 16'h1111;
    burst(4'b1000);
    wait_idle(40);
    grants.delete();
    req = 4'b1011;
    repeat (8) @(negedge clk);
    req = '0;
    wait_idle(40);
    chk("rr_count", 32'(grants.size() >= 4), 32'd1);
    chk("rr_g0", 32'(grants[0]), 32'h1);
    chk("rr_g1", 32'(grants[1]), 32'h2);
    chk("rr_g2", 32'(grants[2]), 32'h8);
    chk("rr_g3", 32'(grants[3]), 32'h1);

    // Backpressure: len 4, ready 1,0,0,1,1,1.
    hs_words.delete(); en_count = 0;
    req_len = 16'h0004;
    patv = 6'b111001;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    for (int i = 0; i < 6; i++) begin
      out_ready = patv[i];
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle(40);
    chk("bp_en", 32'(en_count), 32'd4);
    chk("bp_hs", 32'(hs_words.size()), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < hs_words.size()) chk("bp_seq", hs_words[i+1], lfsr_next(hs_words[i]));
    end

    // Reseed requested mid-burst waits for IDLE.
    loads.delete(); hs_words.delete();
    req_len = 16'h0050;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    reseed_seed = 32'hDEADBEEF;
    reseed_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (reseed_ready) break;
    end
    chk("reseed_reached_idle", 32'(reseed_ready), 32'd1);
    chk("reseed_burst_done", 32'(hs_words.size()), 32'd5);
    @(negedge clk);
    reseed_valid = 1'b0;
    wait_idle(40);
    chk("reseed_loads", 32'(loads.size()), 32'd1);
    chk("reseed_val", loads[0], 32'hDEADBEEF);

    // Zero reseed substitutes SEED.
    loads.delete();
    reseed_seed = 32'd0;
    reseed_valid = 1'b1;
    @(negedge clk);
    reseed_valid = 1'b0;
    wait_idle(40);
    chk("reseed0_loads", 32'(loads.size()), 32'd1);
    chk("reseed0_val", loads[0], 32'h1);

    // Length 0 behaves as 1.
    hs_words.delete(); last_count = 0;
    req_len = 16'h0000;
    burst(4'b0100);
    wait_idle(40);
    chk("len0_hs", 32'(hs_words.size()), 32'd1);
    chk("len0_last", 32'(last_count), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req          = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
      req_len      = 16'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      reseed_valid = ($urandom_range(0, 15) == 0);
      reseed_seed  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
    end
    req = '0; reseed_valid = 1'b0; out_ready = 1'b1;
    wait_idle(100);

    // Reset on the second word of a length-8 burst.
    req_len = 16'h0008;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_load", 32'(lfsr_load), 32'd1);
    chk("rst_seed", lfsr_seed, 32'h1);
`ifdef LFSR_SCHED_STATS_EN
    chk("rst_words", words_total, 32'd0);
`endif
    wait_idle(40);
    hs_words.delete();
    req_len = 16'h0002;
    burst(4'b0001);
    wait_idle(40);
    chk("restart_hs", 32'(hs_words.size()), 32'd2);
    chk("restart_w0", hs_words[0], 32'h1);
    chk("restart_w1", hs_words[1], 32'h3);
`ifdef LFSR_SCHED_STATS_EN
    chk("restart_words", words_total, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Run-length guard.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
